fifo_reader: RTL and testbench

//  Consumer-side controller for the team's byte FIFO. It pops the FIFO whenever data
//  is available and downstream space exists, then presents words on a valid/ready stream.
//  It sits between the FIFO read port and any streaming sink (UART tx, packer, ...).
//  It also keeps a delivered-word counter and a saturating count of FIFO invalid pulses.

---
 rtl/fifo_rd_pkg.sv | 12 +
 rtl/fifo_reader_chk.sv | 18 +
 rtl/reader_obuf.sv | 78 +++++++
 rtl/fifo_reader.sv | 120 ++++++++++++
 tb/tb_fifo_reader.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO consumer-side reader.
package fifo_rd_pkg;

  localparam int unsigned FIFO_RD_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_reader_chk.sv
// Occupancy sanity checker for the reader output buffer.
module fifo_reader_chk #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             reset,
  input logic [OCC_W-1:0] occ
);

  // Occupancy must never exceed the buffer depth
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (occ <= OCC_W'(DEPTH)) else $error("reader obuf occupancy %0d exceeds depth %0d", occ, DEPTH);
    end
  end

endmodule

// File: rtl/reader_obuf.sv
// Small circular output buffer: FIFO-ordered storage between the FIFO read port and the stream.
module reader_obuf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [OCC_W-1:0] occ
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Buffer state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign valid   = (occ_q != '0);
  assign occ     = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Consumer-side FIFO controller: pops when data and downstream space exist, streams words out.
module fifo_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH      = FIFO_RD_WIDTH,
  parameter int unsigned OBUF_DEPTH = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             read_n,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  input  logic             fifo_invalid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] rd_count,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned OCC_W  = $clog2(OBUF_DEPTH + 1);
  localparam int unsigned FILL_W = OCC_W + 1;

  rd_state_e        state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [OCC_W-1:0] occ;
  logic [FILL_W-1:0] fill;
  logic             hs;

  reader_obuf #(
    .WIDTH (WIDTH),
    .DEPTH (OBUF_DEPTH),
    .OCC_W (OCC_W)
  ) u_obuf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight_q),
    .wr_data (fifo_data),
    .rd_en   (hs),
    .rd_data (m_data),
    .valid   (m_valid),
    .occ     (occ)
  );

  fifo_reader_chk #(
    .DEPTH (OBUF_DEPTH),
    .OCC_W (OCC_W)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .occ   (occ)
  );

  // Pop only when the word already in flight plus buffered words leave a free slot
  always_comb begin
    hs     = m_valid & m_ready;
    fill   = FILL_W'(occ) + FILL_W'(inflight_q) - FILL_W'(hs);
    read_n = (state_q == ST_RUN) & ~fifo_empty & (fill < FILL_W'(OBUF_DEPTH));
    busy   = (state_q != ST_IDLE) | m_valid;
  end

  // FSM and counter next-state
  always_comb begin
    state_d     = state_q;
    inflight_d  = read_n;
    rd_count_d  = rd_count_q;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!enable) state_d = ST_STOP;
        else         state_d = ST_RUN;
      end
      ST_STOP: begin
        if (enable)          state_d = ST_RUN;
        else if (!inflight_q) state_d = ST_IDLE;
        else                 state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
    if (hs) begin
      rd_count_d = rd_count_q + CNT_W'(1);
    end else begin
      rd_count_d = rd_count_q;
    end
    if (fifo_invalid && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      inflight_q  <= 1'b0;
      rd_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      rd_count_q  <= rd_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign rd_count  = rd_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader driven by a behavioural byte FIFO.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       reset, fifo_rst_n, enable, m_ready;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       force_inv, force_inv2;

  logic       read_n, m_valid, busy;
  logic [7:0] m_data;
  logic [15:0] rd_count;
  logic [7:0] err_count;

  logic       rn2, mv2, b2;
  logic [7:0] md2;
  logic [15:0] rc2;
  logic [1:0] ec2;

  logic [7:0] fmem [32];
  logic [5:0] fcount;
  logic [4:0] wptr, rptr;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_inv_seen;

  int         pops;
  logic [7:0] outq [$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_reader u_dut (
    .clk (clk), .reset (reset), .enable (enable), .read_n (read_n),
    .fifo_data (fifo_data), .fifo_empty (fifo_empty), .fifo_invalid (force_inv),
    .m_data (m_data), .m_valid (m_valid), .m_ready (m_ready), .busy (busy),
    .rd_count (rd_count), .err_count (err_count)
  );

  fifo_reader #(.ERR_W(2)) u_dut2 (
    .clk (clk), .reset (reset), .enable (1'b0), .read_n (rn2),
    .fifo_data (8'd0), .fifo_empty (1'b1), .fifo_invalid (force_inv2),
    .m_data (md2), .m_valid (mv2), .m_ready (1'b0), .busy (b2),
    .rd_count (rc2), .err_count (ec2)
  );

  assign fifo_empty = (fcount == 6'd0);

  // Behavioural FIFO: one-cycle read latency, sticky flag for pop-on-empty
  always @(posedge clk) begin
    if (!fifo_rst_n) begin
      fcount <= 6'd0; wptr <= 5'd0; rptr <= 5'd0;
      fifo_data <= 8'd0; fifo_inv_seen <= 1'b0;
    end else begin
      if (wr_en) begin
        fmem[wptr] <= wr_data;
        wptr <= wptr + 5'd1;
      end
      if (read_n && !fifo_empty) begin
        fifo_data <= fmem[rptr];
        rptr <= rptr + 5'd1;
      end
      if (read_n && fifo_empty) fifo_inv_seen <= 1'b1;
      fcount <= fcount + 6'(wr_en) - 6'(read_n && !fifo_empty);
    end
  end

  always @(negedge clk) begin
    if (reset && read_n) pops <= pops + 1;
    if (reset && m_valid && m_ready) outq.push_back(m_data);
  end

  initial pops = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [7:0] v);
    wr_en = 1'b1;
    wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input int i);
    if (i < outq.size()) return 32'(outq[i]);
    else return 'x;
  endfunction

  initial begin
    int p0, ob, n;
    reset = 1'b0; fifo_rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
    wr_en = 1'b0; wr_data = 8'd0; force_inv = 1'b0; force_inv2 = 1'b0;
    repeat (3) tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_read_n", read_n, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b1; fifo_rst_n = 1'b1;

    // 1: two words, sink always ready
    fifo_write(8'd3); fifo_write(8'd6);
    chk("t1_idle_no_pop", read_n, 0);
    p0 = pops; ob = outq.size();
    enable = 1'b1; m_ready = 1'b1;
    tick(); chk("t1_rn_c1", read_n, 1); chk("t1_mv_c1", m_valid, 0); chk("t1_busy", busy, 1);
    tick(); chk("t1_rn_c2", read_n, 1); chk("t1_mv_c2", m_valid, 0);
    tick(); chk("t1_rn_c3", read_n, 0); chk("t1_mv_c3", m_valid, 1); chk("t1_md_c3", m_data, 3);
    tick(); chk("t1_mv_c4", m_valid, 1); chk("t1_md_c4", m_data, 6);
    tick(); chk("t1_mv_c5", m_valid, 0);
    repeat (3) tick();
    chk("t1_pops", pops - p0, 2);
    chk("t1_nout", outq.size() - ob, 2);
    chk("t1_out0", qget(ob), 3);
    chk("t1_out1", qget(ob + 1), 6);
    chk("t1_rd_count", rd_count, 2);
    chk("t1_err_count", err_count, 0);

    // 2: backpressure fills the buffer, then back-to-back drain
    m_ready = 1'b0; p0 = pops; ob = outq.size();
    fifo_write(8'd13); fifo_write(8'd4); fifo_write(8'd5); fifo_write(8'd8);
    repeat (3) tick();
    chk("t2_pops_held", pops - p0, 2);
    chk("t2_rn_full", read_n, 0);
    chk("t2_mv_held", m_valid, 1);
    chk("t2_md_held", m_data, 13);
    m_ready = 1'b1;
    tick(); chk("t2_md_b1", m_data, 4);
    tick(); chk("t2_md_b2", m_data, 5);
    tick(); chk("t2_md_b3", m_data, 8);
    tick(); chk("t2_mv_done", m_valid, 0);
    chk("t2_nout", outq.size() - ob, 4);
    chk("t2_out0", qget(ob), 13);
    chk("t2_out1", qget(ob + 1), 4);
    chk("t2_out2", qget(ob + 2), 5);
    chk("t2_out3", qget(ob + 3), 8);
    chk("t2_pops", pops - p0, 4);
    chk("t2_rd_count", rd_count, 6);

    // 3: empty FIFO while running
    p0 = pops;
    repeat (20) tick();
    chk("t3_no_pops", pops - p0, 0);
    chk("t3_read_n", read_n, 0);
    chk("t3_m_valid", m_valid, 0);
    chk("t3_busy_run", busy, 1);

    // 4: invalid pulses, plain and saturating
    force_inv = 1'b1; force_inv2 = 1'b1;
    tick(); tick();
    chk("t4_err2_two", ec2, 2);
    tick();
    force_inv = 1'b0;
    chk("t4_err_three", err_count, 3);
    chk("t4_err2_three", ec2, 3);
    tick(); tick();
    force_inv2 = 1'b0;
    chk("t4_err2_sat", ec2, 3);
    tick();
    chk("t4_err_hold", err_count, 3);

    // 5: drop enable together with the fifth pop
    enable = 1'b0;
    repeat (3) tick();
    chk("t5_idle_busy", busy, 0);
    for (int i = 0; i < 16; i++) fifo_write(8'(20 + i));
    p0 = pops; ob = outq.size(); n = 0;
    m_ready = 1'b1; enable = 1'b1;
    for (int k = 0; k < 40 && n < 5; k++) begin
      if (read_n) begin
        n++;
        if (n == 5) enable = 1'b0;
      end
      tick();
    end
    chk("t5_reached_5", n, 5);
    chk("t5_busy_stop", busy, 1);
    tick(); chk("t5_last_mv", m_valid, 1); chk("t5_last_md", m_data, 24); chk("t5_busy_last", busy, 1);
    tick(); chk("t5_mv_after", m_valid, 0); chk("t5_busy_after", busy, 0);
    repeat (5) tick();
    chk("t5_pops", pops - p0, 5);
    chk("t5_nout", outq.size() - ob, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t5_out%0d", i), qget(ob + i), 20 + i);
    chk("t5_rd_count", rd_count, 11);
    chk("t5_read_n", read_n, 0);

    // 6: reset with two words buffered; remaining FIFO words resume
    m_ready = 1'b0; enable = 1'b1;
    repeat (6) tick();
    chk("t6_mv_pre", m_valid, 1);
    chk("t6_md_pre", m_data, 25);
    reset = 1'b0;
    tick();
    chk("t6_mv_rst", m_valid, 0);
    chk("t6_rn_rst", read_n, 0);
    chk("t6_rdc_rst", rd_count, 0);
    chk("t6_err_rst", err_count, 0);
    chk("t6_busy_rst", busy, 0);
    reset = 1'b1; m_ready = 1'b1; ob = outq.size();
    repeat (30) tick();
    chk("t6_nout", outq.size() - ob, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("t6_out%0d", i), qget(ob + i), 27 + i);
    chk("t6_rd_count", rd_count, 9);
    chk("t6_fifo_empty", fifo_empty, 1);
    chk("no_pop_on_empty", fifo_inv_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
